load_store_unit: RTL and testbench
==================================

# load_store_unit

Request-side controller that sits directly upstream of `data_memory` and is the only driver of its address, write-data and write-enable inputs. It accepts one load or store at a time from the execute stage over a valid/ready handshake and range-checks the address against the populated window. It sequences the one-cycle registered memory read and returns data or a fault over a second valid/ready handshake. It also keeps a saturating count of faulted requests.

## Interface
- `ADDR_LO`, 64, lowest populated data-memory address (inclusive).
- `ADDR_HI`, 255, highest populated data-memory address (inclusive).
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit can accept a request; high exactly in IDLE.
- `req_write`  input  1  1 = store, 0 = load.
- `req_addr`  input  8  byte address.
- `req_wdata`  input  8  store data.
- `resp_valid`  output  1  response present; high exactly in RESP.
- `resp_ready`  input  1  consumer accepts the response.
- `resp_rdata`  output  8  load data; 0 for stores and faults.
- `resp_fault`  output  1  address was outside `ADDR_LO..ADDR_HI`.
- `fault_count`  output  8  faulted requests since reset; saturates at 255.
- `mem_address`  output  8  to `data_memory.data_address`.
- `mem_write_data`  output  8  to `data_memory.write_data`.
- `mem_write_enable`  output  1  to `data_memory.write_enable`.
- `mem_read_data`  input  8  from `data_memory.read_data`; registered in memory, valid one edge after the address is presented with write-enable low.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Acceptance occurs on an edge where `req_valid && req_ready`.
  - On acceptance, latch `req_addr` into `mem_address`, `req_wdata` into `mem_write_data`, and `req_write` into an internal type bit.
  - In range: go to ISSUE.
  - Out of range: go straight to RESP with `resp_fault`=1 and `resp_rdata`=0, and increment `fault_count` unless it is already 255. No memory access is made.
- **ISSUE**
  - `mem_write_enable` = type bit; the memory acts on the next edge.
  - Store: go to RESP with `resp_rdata`=0 and `resp_fault`=0.
  - Load: go to WAIT.
- **WAIT**
  - `mem_write_enable`=0 and `mem_address` is held.
  - On the next edge, `resp_rdata` <= `mem_read_data`, `resp_fault`=0, and the FSM goes to RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata` and `resp_fault` are held stable.
  - On `resp_ready`, go to IDLE.
  - `req_ready` is 0 here, so there is no overlap with the next request.
- `mem_write_enable` is combinational and high only in ISSUE with the type bit set.
- `mem_address` and `mem_write_data` are registers that change only on acceptance. A faulted request does not update `mem_address`; it keeps its last in-range value.
- Range check is unsigned: `ADDR_LO <= req_addr <= ADDR_HI`.

## Timing
- Reset values:
  - FSM = IDLE, so `req_ready`=1 and `resp_valid`=0.
  - `resp_rdata`=0, `resp_fault`=0, `fault_count`=0.
  - `mem_address`=`ADDR_LO`, `mem_write_data`=0, `mem_write_enable`=0.
- Latency from the acceptance edge to the first cycle with `resp_valid` high:
  - Fault: 1 edge.
  - Store: 2 edges; memory written at the edge leaving ISSUE.
  - Load: 3 edges; data sampled at the edge leaving WAIT.
- With `resp_ready` held high, throughput is one load per 4 cycles, one store per 3, one fault per 2.
- `req_valid` may drop without acceptance; no state change.
- Asserting `reset_n` low while in ISSUE forces `mem_write_enable` low at once. If reset arrives before the edge, the store is lost; the memory array itself is never reset.
- Asserting reset in RESP discards the pending response; `fault_count` clears.
- A load to an address stored by the immediately preceding request returns the new data.

## Test plan
- Reset, then store 0xA5 to 0x50 and load from 0x50:
  - Store: `resp_valid` 2 edges after acceptance, `resp_fault`=0, `resp_rdata`=0.
  - Load: `resp_valid` 3 edges after acceptance, `resp_rdata`=0xA5.
- Load from 0x3F, then store to 0x00:
  - Each gives `resp_valid` 1 edge after acceptance with `resp_fault`=1.
  - `mem_write_enable` never rises.
  - `fault_count`=2.
- Boundaries: store/load round-trip at 0x40 and at 0xFF both succeed.
- Hold `resp_ready` low for 5 cycles in RESP:
  - `resp_valid`, `resp_rdata` and `resp_fault` stay stable.
  - `req_ready`=0 throughout.
  - The second `req_valid` is not accepted until the cycle after the `resp_ready` handshake.
- Issue 260 faulting requests: `fault_count` reads 255 and stays there.
- Assert `reset_n` mid-ISSUE of a store of 0x77 to 0x60:
  - `mem_write_enable` drops immediately and all outputs take their reset values.
  - A subsequent load of 0x60 returns the prior contents, not 0x77.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response handshake for the load/store unit.
// master = execute stage side, slave = load_store_unit side.
interface load_store_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       resp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller in front of data_memory: range check,
// store/load sequencing around the registered read, fault reporting and counting.
module load_store_unit #(
    parameter logic [7:0] ADDR_LO = 8'd64,
    parameter logic [7:0] ADDR_HI = 8'd255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    load_store_unit_if.slave         lsu,
    output logic [7:0]               fault_count,
    output logic [7:0]               mem_address,
    output logic [7:0]               mem_write_data,
    output logic                     mem_write_enable,
    input  logic [7:0]               mem_read_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state_q, state_d;
    logic       type_q, type_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       fault_q, fault_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       accept;
    logic       in_range;

    assign accept = lsu.req_valid && (state_q == IDLE);
    // Widened compare keeps the check meaningful when a bound sits at the type limit.
    assign in_range = ({1'b0, lsu.req_addr} >= {1'b0, ADDR_LO}) &&
                      ({1'b0, lsu.req_addr} <= {1'b0, ADDR_HI});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            type_q  <= 1'b0;
            addr_q  <= ADDR_LO;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            fault_q <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    type_d = lsu.req_write;
                    if (in_range) begin
                        addr_d  = lsu.req_addr;
                        wdata_d = lsu.req_wdata;
                        state_d = ISSUE;
                    end else begin
                        // Faults never touch memory, so the address bus keeps its last legal value.
                        rdata_d = 8'd0;
                        fault_d = 1'b1;
                        if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (type_q) begin
                    rdata_d = 8'd0;
                    fault_d = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d = mem_read_data;
                fault_d = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (lsu.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu.req_ready    = (state_q == IDLE);
        lsu.resp_valid   = (state_q == RESP);
        mem_write_enable = (state_q == ISSUE) && type_q;
    end

    assign lsu.resp_rdata  = rdata_q;
    assign lsu.resp_fault  = fault_q;
    assign fault_count     = fcnt_q;
    assign mem_address     = addr_q;
    assign mem_write_data  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded random bench for load_store_unit with a behavioural data memory
// and an array-based reference of memory contents and fault count.
module tb_load_store_unit;
    localparam int LO = 64;
    localparam int HI = 255;

    typedef struct {
        logic       fault;
        logic [7:0] rdata;
        int         lat;
        logic [7:0] fcnt;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] fault_count, mem_address, mem_write_data, mem_read_data;
    logic       mem_write_enable;

    load_store_unit_if bus();

    load_store_unit #(.ADDR_LO(8'd64), .ADDR_HI(8'd255)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .lsu              (bus),
        .fault_count      (fault_count),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed(int i);
        return 8'(i * 53 + 17);
    endfunction

    // Behavioural data_memory: write on edge, registered read, never reset.
    logic [7:0] mem [256];
    bit         mem_seeded = 1'b0;
    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
            mem_seeded <= 1'b1;
        end else begin
            if (mem_write_enable) mem[mem_address] <= mem_write_data;
            mem_read_data <= mem[mem_address];
        end
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit   rand_rr = 1'b0;
    bit   rr_man  = 1'b1;
    bit   rr_rand = 1'b1;
    always @(posedge clk) begin
        #1;
        rr_rand = ($urandom_range(0, 3) != 0);
    end
    assign bus.resp_ready = rand_rr ? rr_rand : rr_man;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] ref_mem [256];
    int         fmodel = 0;
    int         we_cnt = 0;
    int         hs_edge = -1;
    exp_t       sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle of each response.
    exp_t       m_e;
    bit         prev_v = 1'b0;
    logic [7:0] h_rd;
    logic       h_f;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.resp_valid) begin
                chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd0, 32'd1);
                    end else begin
                        m_e = sb.pop_front();
                        chk("resp_fault", 32'(bus.resp_fault), 32'(m_e.fault));
                        chk("resp_rdata", 32'(bus.resp_rdata), 32'(m_e.rdata));
                        chk("latency", 32'(cyc - m_e.acc + 1), 32'(m_e.lat));
                        chk("fault_count", 32'(fault_count), 32'(m_e.fcnt));
                    end
                    h_rd = bus.resp_rdata;
                    h_f  = bus.resp_fault;
                end else begin
                    chk("hold_rdata", 32'(bus.resp_rdata), 32'(h_rd));
                    chk("hold_fault", 32'(bus.resp_fault), 32'(h_f));
                end
                if (bus.resp_ready) hs_edge = cyc + 1;
            end
            prev_v = bus.resp_valid && !bus.resp_ready;
            if (mem_write_enable) we_cnt++;
        end
    end

    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d, output int acc);
        exp_t e;
        int   n = 0;
        int   ai = int'(a);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc + 1;
        e.acc = acc;
        if (ai < LO || ai > HI) begin
            e.fault = 1'b1;
            e.rdata = 8'd0;
            e.lat   = 1;
            if (fmodel < 255) fmodel++;
        end else if (w) begin
            ref_mem[a] = d;
            e.fault = 1'b0;
            e.rdata = 8'd0;
            e.lat   = 2;
        end else begin
            e.fault = 1'b0;
            e.rdata = ref_mem[a];
            e.lat   = 3;
        end
        e.fcnt = 8'(fmodel);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
        chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
        chk({tag, "_fault_count"}, 32'(fault_count), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'(LO));
        chk({tag, "_mem_wdata"}, 32'(mem_write_data), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n, w0, acc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd0;
        bus.req_wdata = 8'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b1, 8'h50, 8'hA5, acc);
        do_req(1'b0, 8'h50, 8'h00, acc);
        drain();

        w0 = we_cnt;
        do_req(1'b0, 8'h3F, 8'h00, acc);
        do_req(1'b1, 8'h00, 8'h12, acc);
        drain();
        chk("fault_no_we", 32'(we_cnt), 32'(w0));
        chk("fault_count_2", 32'(fault_count), 32'd2);

        do_req(1'b1, 8'h40, 8'h3C, acc);
        do_req(1'b0, 8'h40, 8'h00, acc);
        do_req(1'b1, 8'hFF, 8'hC3, acc);
        do_req(1'b0, 8'hFF, 8'h00, acc);
        drain();

        // Back-pressure: response held for five cycles, next request queued behind it.
        rr_man = 1'b0;
        a2 = -1;
        fork
            begin
                do_req(1'b1, 8'h70, 8'h5A, a1);
                do_req(1'b0, 8'h70, 8'h00, a2);
            end
            begin
                n = 0;
                while (!bus.resp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1;
                rr_man = 1'b1;
            end
        join
        chk("accept_after_handshake", 32'(a2), 32'(hs_edge + 1));
        drain();

        // Reset while a store sits in ISSUE.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h60;
        bus.req_wdata = 8'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("we_in_issue", 32'(mem_write_enable), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_issue");
        fmodel = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 8'h60, 8'h00, acc);
        drain();

        rand_rr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            case ($urandom_range(0, 3))
                0:       ra = 8'($urandom_range(0, 63));
                1:       ra = 8'($urandom_range(64, 255));
                default: ra = 8'($urandom_range(240, 255));
            endcase
            do_req(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)), acc);
        end
        drain();
        rand_rr = 1'b0;

        for (int i = 0; i < 260; i++)
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), acc);
        drain();
        chk("fault_count_sat", 32'(fault_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
